// File: rtl/serial_subtractor_nbit_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and default width.
// Optional feature macro used across this slice: SERIAL_SUB_SIGNED_OVF_EN.
package serial_sub_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;

   localparam int DEFAULT_NUM_BITS = 4;

endpackage

// File: rtl/serial_subtractor_nbit_if.sv
// Start/done operand bus of the bit-serial subtractor, plus a debug view of its FSM state.
// SERIAL_SUB_SIGNED_OVF_EN adds the signed_ovf result flag.
interface serial_subtractor_nbit_if
   import serial_sub_pkg::*;
#(
   parameter int NUM_BITS = DEFAULT_NUM_BITS
) ();

   // Handshake: start is honoured only while busy=0 (IDLE or DONE); a/b/borrow_in are
   // sampled on that same edge. done is a one-cycle pulse; results hold until the next done.
   logic                start;
   logic [NUM_BITS-1:0] a;
   logic [NUM_BITS-1:0] b;
   logic                borrow_in;
   logic                busy;
   logic                done;
   logic [NUM_BITS-1:0] diff;
   logic                underflow;
   sub_state_t          dbg_state;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
   logic                signed_ovf;

   modport master (output start, a, b, borrow_in,
                   input  busy, done, diff, underflow, dbg_state, signed_ovf);
   modport slave  (input  start, a, b, borrow_in,
                   output busy, done, diff, underflow, dbg_state, signed_ovf);
`else
   modport master (output start, a, b, borrow_in,
                   input  busy, done, diff, underflow, dbg_state);
   modport slave  (input  start, a, b, borrow_in,
                   output busy, done, diff, underflow, dbg_state);
`endif

endinterface

// File: rtl/serial_subtractor_nbit_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with the borrow out of this bit position.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial N-bit subtractor (a - b - borrow_in), LSB first, behind a start/done handshake.
// SERIAL_SUB_SIGNED_OVF_EN adds a registered two's-complement overflow flag.
module serial_subtractor_nbit
   import serial_sub_pkg::*;
#(
   parameter int NUM_BITS = DEFAULT_NUM_BITS
) (
   input logic                     clk,
   input logic                     rst,
   serial_subtractor_nbit_if.slave bus
);

   localparam int              CNT_W    = $clog2(NUM_BITS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BITS - 1);

   sub_state_t          state_q, state_d;
   logic [NUM_BITS-1:0] a_sh_q, a_sh_d;
   logic [NUM_BITS-1:0] b_sh_q, b_sh_d;
   logic [NUM_BITS-1:0] res_q, res_d;
   logic [NUM_BITS-1:0] diff_q, diff_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                br_q, br_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                uf_q, uf_d;
   logic                bit_d, bit_bout;
   logic                accept;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
   logic                ovf_q, ovf_d;
`endif

   full_subtractor u_fs (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .bin  (br_q),
      .d    (bit_d),
      .bout (bit_bout)
   );

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      diff_d  = diff_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
      uf_d    = uf_q;
      done_d  = 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      ovf_d   = ovf_q;
`endif
      accept  = bus.start && (state_q == IDLE || state_q == DONE);

      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               a_sh_d  = bus.a;
               b_sh_d  = bus.b;
               br_d    = bus.borrow_in;
               res_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            res_d  = {bit_d, res_q[NUM_BITS-1:1]};
            br_d   = bit_bout;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               state_d = DONE;
               done_d  = 1'b1;
               diff_d  = res_d;
               uf_d    = bit_bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
               // On the last bit the operand LSBs are the original sign bits.
               ovf_d   = (a_sh_q[0] ^ b_sh_q[0]) & (bit_d ^ a_sh_q[0]);
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == SHIFT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         uf_q    <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         uf_q    <= uf_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.diff      = diff_q;
   assign bus.underflow = uf_q;
   assign bus.dbg_state = state_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
   assign bus.signed_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Directed bench for serial_subtractor_nbit at NUM_BITS=4: vector table, multi-cycle corner
// sequences and an exhaustive sweep against an arithmetic reference.
module tb_serial_subtractor_nbit;
   import serial_sub_pkg::*;

   localparam int W = 4;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] exp_diff;
      logic         exp_uf;
      logic         exp_ovf;
   } vec_t;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [W:0] exp_q[$];

   serial_subtractor_nbit_if #(.NUM_BITS(W)) bus ();

   serial_subtractor_nbit #(.NUM_BITS(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one operation from the current (idle or done) cycle and waits for done.
   task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                         output logic [W-1:0] od, output logic ouf, output logic oovf,
                         output int lat, output int busy_cnt);
      bus.a         = ia;
      bus.b         = ib;
      bus.borrow_in = ibin;
      bus.start     = 1'b1;
      step();
      bus.start     = 1'b0;
      bus.a         = W'($urandom_range(0, 15));
      bus.b         = W'($urandom_range(0, 15));
      bus.borrow_in = 1'($urandom_range(0, 1));
      lat      = 0;
      busy_cnt = 0;
      while (!bus.done && lat < 20) begin
         if (bus.busy) busy_cnt++;
         step();
         lat++;
      end
      od  = bus.diff;
      ouf = bus.underflow;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      oovf = bus.signed_ovf;
`else
      oovf = 1'b0;
`endif
   endtask

   initial begin
      vec_t         vecs[10];
      logic [W-1:0] got_d;
      logic         got_uf;
      logic         got_ovf;
      int           lat;
      int           bcnt;
      int           done_seen;
      logic [W:0]   exp_v;

      vecs[0] = '{4'd0,  4'd1,  1'b0, 4'd15, 1'b1, 1'b0};
      vecs[1] = '{4'd5,  4'd5,  1'b1, 4'd15, 1'b1, 1'b0};
      vecs[2] = '{4'd5,  4'd5,  1'b0, 4'd0,  1'b0, 1'b0};
      vecs[3] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0};
      vecs[4] = '{4'd3,  4'd9,  1'b0, 4'd10, 1'b1, 1'b1};
      vecs[5] = '{4'd15, 4'd0,  1'b1, 4'd14, 1'b0, 1'b0};
      vecs[6] = '{4'd8,  4'd1,  1'b0, 4'd7,  1'b0, 1'b1};
      vecs[7] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1, 1'b0};
      vecs[8] = '{4'd9,  4'd3,  1'b0, 4'd6,  1'b0, 1'b1};
      vecs[9] = '{4'd10, 4'd5,  1'b0, 4'd5,  1'b0, 1'b1};

      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.borrow_in = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
      check("reset_busy", 32'(bus.busy), 0);
      check("reset_done", 32'(bus.done), 0);
      check("reset_diff", 32'(bus.diff), 0);
      check("reset_underflow", 32'(bus.underflow), 0);
      check("reset_state", 32'(bus.dbg_state), 32'(IDLE));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      check("reset_signed_ovf", 32'(bus.signed_ovf), 0);
`endif

      // 9 - 3: latency, busy window, one-cycle done, held result
      run_op(4'd9, 4'd3, 1'b0, got_d, got_uf, got_ovf, lat, bcnt);
      check("basic_latency", 32'(lat), 4);
      check("basic_busy_cycles", 32'(bcnt), 4);
      check("basic_diff", 32'(got_d), 6);
      check("basic_underflow", 32'(got_uf), 0);
      check("basic_busy_at_done", 32'(bus.busy), 0);
      step();
      check("basic_done_pulse_width", 32'(bus.done), 0);
      check("basic_diff_held", 32'(bus.diff), 6);
      check("basic_state_idle", 32'(bus.dbg_state), 32'(IDLE));

      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].bin, got_d, got_uf, got_ovf, lat, bcnt);
         check($sformatf("vec%0d_latency", i), 32'(lat), 4);
         check($sformatf("vec%0d_diff", i), 32'(got_d), 32'(vecs[i].exp_diff));
         check($sformatf("vec%0d_underflow", i), 32'(got_uf), 32'(vecs[i].exp_uf));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
         check($sformatf("vec%0d_signed_ovf", i), 32'(got_ovf), 32'(vecs[i].exp_ovf));
`endif
      end
      step();

      // reset in the middle of 12 - 4 aborts with no done and cleared outputs
      bus.a     = 4'd12;
      bus.b     = 4'd4;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      step();
      check("abort_busy_before_rst", 32'(bus.busy), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_busy", 32'(bus.busy), 0);
      check("abort_done", 32'(bus.done), 0);
      check("abort_diff", 32'(bus.diff), 0);
      check("abort_underflow", 32'(bus.underflow), 0);
      check("abort_state", 32'(bus.dbg_state), 32'(IDLE));
      done_seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.done) done_seen++;
         step();
      end
      check("abort_no_done", 32'(done_seen), 0);
      run_op(4'd12, 4'd4, 1'b0, got_d, got_uf, got_ovf, lat, bcnt);
      check("after_abort_latency", 32'(lat), 4);
      check("after_abort_diff", 32'(got_d), 8);
      check("after_abort_underflow", 32'(got_uf), 0);
      step();

      // start held high; operands change mid-op; restart accepted in DONE
      bus.a         = 4'd7;
      bus.b         = 4'd2;
      bus.borrow_in = 1'b0;
      bus.start     = 1'b1;
      step();
      bus.a = 4'd1;
      bus.b = 4'd1;
      lat   = 0;
      while (!bus.done && lat < 20) begin
         step();
         lat++;
      end
      check("hold_first_latency", 32'(lat), 4);
      check("hold_first_diff", 32'(bus.diff), 5);
      step();
      bus.start = 1'b0;
      check("hold_restart_busy", 32'(bus.busy), 1);
      check("hold_restart_done_low", 32'(bus.done), 0);
      check("hold_diff_kept", 32'(bus.diff), 5);
      lat = 0;
      while (!bus.done && lat < 20) begin
         step();
         lat++;
      end
      check("hold_second_latency", 32'(lat), 4);
      check("hold_second_diff", 32'(bus.diff), 0);
      check("hold_second_underflow", 32'(bus.underflow), 0);
      step();

      // exhaustive sweep against a - b - borrow_in
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               exp_v[W-1:0] = W'(ia - ib - ic);
               exp_v[W]     = (ia < ib + ic);
               exp_q.push_back(exp_v);
               run_op(W'(ia), W'(ib), 1'(ic), got_d, got_uf, got_ovf, lat, bcnt);
               exp_v = exp_q.pop_front();
               check($sformatf("sweep_a%0d_b%0d_c%0d", ia, ib, ic),
                     32'({got_uf, got_d}), 32'(exp_v));
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
